// File: rtl/bus_pkg.sv
// Shared bus definitions used by the memory responder and the CPU core.
package bus_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 32;
endpackage

// File: rtl/bus_mem_array.sv
// Single-port synchronous RAM with registered read, written to map onto block RAM.
module bus_mem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clock,
    input  logic              we,
    input  logic [IDX_W-1:0]  index,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];

    // Read-first: a write in the same cycle returns the old word.
    always_ff @(posedge clock) begin
        if (we) r_mem[index] <= wdata;
        rdata <= r_mem[index];
    end
endmodule

// File: rtl/bus_memory_responder.sv
// Memory-side bus responder: one outstanding request, programmable wait states,
// tri-state read data during the single ack cycle.
module bus_memory_responder
    import bus_pkg::*;
#(
    parameter int                DATA_W      = DEF_DATA_W,
    parameter int                ADDR_W      = DEF_ADDR_W,
    parameter int                DEPTH       = 1024,
    parameter logic [ADDR_W-1:0] BASE        = '0,
    parameter int                WAIT_STATES = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              rw,
    inout  wire  [DATA_W-1:0] data,
    input  logic              req,
    output logic              ack,
    output logic              err,
    output logic              busy
);
    localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [3:0]        LAST    = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rw;
    logic [DATA_W-1:0] r_wdata;
    logic              r_in_range;
    logic              r_ack;
    logic              r_err;
    logic              r_busy;

    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] w_off;
    logic              w_rw;
    logic [DATA_W-1:0] w_wdata;
    logic              w_in_range;
    logic              w_enter_ack;
    logic              w_we;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_rdata;

    // With zero wait states the RAM is accessed on the accept edge itself,
    // so the live bus inputs feed the RAM while idle.
    assign w_addr      = (r_state == IDLE) ? address : r_addr;
    assign w_rw        = (r_state == IDLE) ? rw      : r_rw;
    assign w_wdata     = (r_state == IDLE) ? data    : r_wdata;
    assign w_off       = w_addr - BASE;
    assign w_in_range  = (w_addr >= BASE) && (w_off < DEPTH_A);
    assign w_idx       = w_off[IDX_W-1:0];
    assign w_enter_ack = ((r_state == IDLE) && req && (WAIT_STATES == 0)) ||
                         ((r_state == WAIT) && (r_cnt == LAST));
    assign w_we        = !reset && w_enter_ack && (w_rw == RW_WRITE) && w_in_range;

    bus_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clock (clock),
        .we    (w_we),
        .index (w_idx),
        .wdata (w_wdata),
        .rdata (w_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ack <= 1'b0;
                    r_err <= 1'b0;
                    if (req) begin
                        r_addr     <= address;
                        r_rw       <= rw;
                        r_wdata    <= data;
                        r_in_range <= w_in_range;
                        r_busy     <= 1'b1;
                        r_cnt      <= '0;
                        if (WAIT_STATES == 0) begin
                            r_state <= ACK;
                            r_ack   <= 1'b1;
                            r_err   <= !w_in_range;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == LAST) begin
                        r_state <= ACK;
                        r_ack   <= 1'b1;
                        r_err   <= !r_in_range;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ACK: begin
                    r_state <= IDLE;
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ack  = r_ack;
    assign err  = r_err;
    assign busy = r_busy;

    // Out-of-range reads still complete, returning zero alongside err.
    assign data = ((r_state == ACK) && (r_rw == RW_READ)) ?
                  (r_in_range ? w_rdata : '0) : 'z;
endmodule

// File: tb/tb_bus_memory_responder.sv
// Directed bench: four responder instances with different wait-state/base settings.
module tb_bus_memory_responder;
    localparam logic [31:0] ZBUS = 32'hFFFF_FFFF;  // undriven bus reads as pulled-up ones

    logic        clk;
    logic        rst  [4];
    logic        req  [4];
    logic        rw   [4];
    logic [31:0] adr  [4];
    logic [31:0] wd   [4];
    logic        wen  [4];
    logic        ack  [4];
    logic        err  [4];
    logic        busy [4];
    wire  [31:0] bus0, bus1, bus2, bus3;

    int checks = 0;
    int errors = 0;

    assign bus0 = wen[0] ? wd[0] : 32'hz;
    assign bus1 = wen[1] ? wd[1] : 32'hz;
    assign bus2 = wen[2] ? wd[2] : 32'hz;
    assign bus3 = wen[3] ? wd[3] : 32'hz;
    pullup (bus0);
    pullup (bus1);
    pullup (bus2);
    pullup (bus3);

    bus_memory_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .BASE(32'h0), .WAIT_STATES(2)) dut_w2 (
        .clock(clk), .reset(rst[0]), .address(adr[0]), .rw(rw[0]), .data(bus0),
        .req(req[0]), .ack(ack[0]), .err(err[0]), .busy(busy[0]));
    bus_memory_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .BASE(32'h0), .WAIT_STATES(0)) dut_w0 (
        .clock(clk), .reset(rst[1]), .address(adr[1]), .rw(rw[1]), .data(bus1),
        .req(req[1]), .ack(ack[1]), .err(err[1]), .busy(busy[1]));
    bus_memory_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .BASE(32'h0), .WAIT_STATES(3)) dut_w3 (
        .clock(clk), .reset(rst[2]), .address(adr[2]), .rw(rw[2]), .data(bus2),
        .req(req[2]), .ack(ack[2]), .err(err[2]), .busy(busy[2]));
    bus_memory_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .BASE(32'h100), .WAIT_STATES(1)) dut_b1 (
        .clock(clk), .reset(rst[3]), .address(adr[3]), .rw(rw[3]), .data(bus3),
        .req(req[3]), .ack(ack[3]), .err(err[3]), .busy(busy[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] get_bus(input int k);
        case (k)
            0:       return bus0;
            1:       return bus1;
            2:       return bus2;
            default: return bus3;
        endcase
    endfunction

    // Runs one transaction and reports what was observed; samples land 2 time units after edges.
    task automatic xfer(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic e, output logic [31:0] rd,
                        output logic zb, output logic za, output logic b_acc, output logic b_after);
        req[k] = 1'b1; rw[k] = w; adr[k] = a; wd[k] = d; wen[k] = w;
        @(posedge clk); #1;
        req[k] = 1'b0; wen[k] = 1'b0;
        #1;
        b_acc = busy[k]; zb = 1'b1; lat = -1; e = 1'b0; rd = '0;
        for (int c = 1; c <= 20; c++) begin
            if (ack[k]) begin
                lat = c; e = err[k]; rd = get_bus(k);
                break;
            end
            if (get_bus(k) !== ZBUS) zb = 1'b0;
            @(posedge clk); #2;
        end
        @(posedge clk); #2;
        za = (get_bus(k) === ZBUS) && !ack[k];
        b_after = busy[k];
    endtask

    task automatic test_reset();
        req[0] = 1'b1; rw[0] = 1'b0; adr[0] = 32'd5;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #2;
            checks++; if (ack[0] !== 1'b0) begin errors++; $display("FAIL reset_ack cyc%0d got %b exp 0", i, ack[0]); end
            checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL reset_err cyc%0d got %b exp 0", i, err[0]); end
            checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL reset_busy cyc%0d got %b exp 0", i, busy[0]); end
            checks++; if (bus0 !== ZBUS) begin errors++; $display("FAIL reset_data cyc%0d got %h exp Z", i, bus0); end
        end
        req[0] = 1'b0;
        for (int k = 0; k < 4; k++) rst[k] = 1'b0;
        @(posedge clk); #2;
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL reset_no_accept got busy %b exp 0", busy[0]); end
    endtask

    task automatic test_write_read();
        int lat; logic e, zb, za, ba, bf; logic [31:0] rd;
        xfer(0, 1'b1, 32'd5, 32'hDEAD_BEEF, lat, e, rd, zb, za, ba, bf);
        checks++; if (lat !== 3) begin errors++; $display("FAIL wr_latency got %0d exp 3", lat); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL wr_err got %b exp 0", e); end
        checks++; if (rd !== ZBUS) begin errors++; $display("FAIL wr_bus_undriven got %h exp Z", rd); end
        checks++; if (ba !== 1'b1) begin errors++; $display("FAIL wr_busy_accept got %b exp 1", ba); end
        checks++; if (bf !== 1'b0) begin errors++; $display("FAIL wr_busy_after got %b exp 0", bf); end
        xfer(0, 1'b0, 32'd5, 32'h0, lat, e, rd, zb, za, ba, bf);
        checks++; if (lat !== 3) begin errors++; $display("FAIL rd_latency got %0d exp 3", lat); end
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data got %h exp deadbeef", rd); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL rd_err got %b exp 0", e); end
        checks++; if (zb !== 1'b1) begin errors++; $display("FAIL rd_z_before got %b exp 1", zb); end
        checks++; if (za !== 1'b1) begin errors++; $display("FAIL rd_z_after got %b exp 1", za); end
    endtask

    task automatic test_out_of_range();
        int lat; logic e, zb, za, ba, bf; logic [31:0] rd;
        xfer(0, 1'b1, 32'd1023, 32'h3FF0_3FF0, lat, e, rd, zb, za, ba, bf);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL oor_last_word_err got %b exp 0", e); end
        xfer(0, 1'b0, 32'd1024, 32'h0, lat, e, rd, zb, za, ba, bf);
        checks++; if (lat !== 3) begin errors++; $display("FAIL oor_rd_latency got %0d exp 3", lat); end
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL oor_rd_err got %b exp 1", e); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oor_rd_data got %h exp 0", rd); end
        xfer(0, 1'b1, 32'hFFFF_FFFF, 32'h1234, lat, e, rd, zb, za, ba, bf);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL oor_wr_err got %b exp 1", e); end
        xfer(0, 1'b0, 32'd1023, 32'h0, lat, e, rd, zb, za, ba, bf);
        checks++; if (rd !== 32'h3FF0_3FF0) begin errors++; $display("FAIL oor_wr_no_effect got %h exp 3ff03ff0", rd); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL last_word_rd_err got %b exp 0", e); end
    endtask

    task automatic test_back_to_back();
        int lat; logic e, zb, za, ba, bf; logic [31:0] rd;
        logic [31:0] exp_v [3];
        exp_v[0] = 32'hA; exp_v[1] = 32'hB; exp_v[2] = 32'hC;
        for (int i = 0; i < 3; i++) begin
            xfer(1, 1'b1, 32'(i), exp_v[i], lat, e, rd, zb, za, ba, bf);
            checks++; if (lat !== 1) begin errors++; $display("FAIL w0_wr_latency%0d got %0d exp 1", i, lat); end
        end
        req[1] = 1'b1; rw[1] = 1'b0; adr[1] = 32'd0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            checks++; if (ack[1] !== 1'b1) begin errors++; $display("FAIL b2b_ack%0d got %b exp 1", i, ack[1]); end
            checks++; if (bus1 !== exp_v[i]) begin errors++; $display("FAIL b2b_data%0d got %h exp %h", i, bus1, exp_v[i]); end
            if (i < 2) adr[1] = 32'(i + 1);
            else req[1] = 1'b0;
            @(posedge clk); #2;
            checks++; if (ack[1] !== 1'b0) begin errors++; $display("FAIL b2b_gap%0d got ack %b exp 0", i, ack[1]); end
            checks++; if (bus1 !== ZBUS) begin errors++; $display("FAIL b2b_gap_z%0d got %h exp Z", i, bus1); end
        end
    endtask

    task automatic test_reset_mid_wait();
        int lat; logic e, zb, za, ba, bf; logic [31:0] rd;
        logic saw_ack;
        xfer(2, 1'b1, 32'd7, 32'h11, lat, e, rd, zb, za, ba, bf);
        checks++; if (lat !== 4) begin errors++; $display("FAIL w3_wr_latency got %0d exp 4", lat); end
        req[2] = 1'b1; rw[2] = 1'b1; adr[2] = 32'd7; wd[2] = 32'h55; wen[2] = 1'b1;
        @(posedge clk); #1;
        req[2] = 1'b0; wen[2] = 1'b0;
        #1;
        checks++; if (busy[2] !== 1'b1) begin errors++; $display("FAIL midwait_busy got %b exp 1", busy[2]); end
        @(posedge clk); #2;
        rst[2] = 1'b1;
        @(posedge clk); #2;
        rst[2] = 1'b0;
        checks++; if (busy[2] !== 1'b0) begin errors++; $display("FAIL midwait_busy_cleared got %b exp 0", busy[2]); end
        saw_ack = ack[2];
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #2;
            saw_ack = saw_ack | ack[2];
        end
        checks++; if (saw_ack !== 1'b0) begin errors++; $display("FAIL midwait_no_ack got %b exp 0", saw_ack); end
        xfer(2, 1'b0, 32'd7, 32'h0, lat, e, rd, zb, za, ba, bf);
        checks++; if (rd !== 32'h11) begin errors++; $display("FAIL midwait_no_write got %h exp 11", rd); end
    endtask

    task automatic test_base_offset();
        int lat; logic e, zb, za, ba, bf; logic [31:0] rd;
        xfer(3, 1'b1, 32'h100, 32'h77, lat, e, rd, zb, za, ba, bf);
        checks++; if (lat !== 2) begin errors++; $display("FAIL base_wr_latency got %0d exp 2", lat); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL base_wr_err got %b exp 0", e); end
        xfer(3, 1'b0, 32'h100, 32'h0, lat, e, rd, zb, za, ba, bf);
        checks++; if (rd !== 32'h77) begin errors++; $display("FAIL base_rd_data got %h exp 77", rd); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL base_rd_err got %b exp 0", e); end
        xfer(3, 1'b0, 32'hFF, 32'h0, lat, e, rd, zb, za, ba, bf);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL base_below_err got %b exp 1", e); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL base_below_data got %h exp 0", rd); end
        xfer(3, 1'b0, 32'h500, 32'h0, lat, e, rd, zb, za, ba, bf);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL base_above_err got %b exp 1", e); end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            rst[k] = 1'b1; req[k] = 1'b0; rw[k] = 1'b0; adr[k] = '0; wd[k] = '0; wen[k] = 1'b0;
        end
        test_reset();
        test_write_read();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_wait();
        test_base_offset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0d checks", checks);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/bus_memory_responder.md
Name: bus_memory_responder

Overview:
Memory-side responder for the CPU's word-addressed memory bus (address, rw, shared data). It accepts one request at a time and inserts a configurable number of wait states. Read data is driven onto the tri-state data bus. Each request is completed with a one-cycle ack pulse. It sits between the CPU core and on-chip RAM and backs instruction fetch and data accesses in the same address map.

Parameters:
DATA_W, 32, width of data bus and memory word
ADDR_W, 32, width of address bus
DEPTH, 1024, number of words in the memory array
BASE, 0, first word address decoded by this responder
WAIT_STATES, 1, extra cycles between request accept and ack (0 allowed, max 15)

Ports:
clock  input  1  single system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
address  input  ADDR_W  word address from initiator
rw  input  1  0 = read, 1 = write
data  inout  DATA_W  shared data bus: sampled on write accept, driven only during read ack
req  input  1  initiator request; address/rw/data valid while high
ack  output  1  one-cycle completion pulse
err  output  1  valid with ack; 1 = address outside [BASE, BASE+DEPTH)
busy  output  1  high from accept until the cycle after ack

Behaviour:
- Reset (clock edge with reset=1): state IDLE, ack=0, err=0, busy=0, data high-Z, wait counter 0. Memory contents are not cleared.
- Reset has priority over all other activity.
- Reset in WAIT or ACK aborts the transaction and performs no memory write.
- States:
  - IDLE: on edge with req=1, latch address, rw and write data; set in_range = (address >= BASE) && (address - BASE < DEPTH); busy=1. Go to WAIT if WAIT_STATES>0, else ACK. With req=0, remain in IDLE.
  - WAIT: counter counts 0..WAIT_STATES-1, then go to ACK. req and address are ignored here; values latched at accept are used.
  - ACK: ack=1 and err=!in_range for exactly one cycle, then IDLE. busy stays 1 through ACK and drops at the edge leaving it.
- Write:
  - in range: mem[address-BASE] is updated at the edge entering ACK. data is never driven.
  - out of range: no write, err=1.
- Read:
  - in range: read word is registered at the edge entering ACK and driven on data only while in ACK.
  - out of range: drives 0 with err=1.
  - data is high-Z in all other states.
- Latency: ack is high in cycle N+1 after the accept cycle, where N = WAIT_STATES. WAIT_STATES=0 gives ack the cycle after accept.
- Back-to-back: a req still high in the cycle after ack (state IDLE) is accepted as a new transaction. There is no combinational path from req to ack.
- Read-after-write to the same address returns the new value. Write-to-read ordering is guaranteed by the single outstanding transaction.
- Address arithmetic is unsigned ADDR_W bits. The index is address-BASE truncated to clog2(DEPTH) bits after the range check.
- The initiator must not drive data during a read transaction. Bus contention is an initiator fault; the responder does not detect it.

Decomposition:
- Shared package bus_pkg:
  - state enum {IDLE, WAIT, ACK}
  - constants RW_READ=0, RW_WRITE=1
  - default DATA_W/ADDR_W
- The CPU core imports the same package.
- One natural sub-module, bus_mem_array: single-port synchronous RAM.
  - Inputs: clock, we, index, wdata.
  - Output: registered rdata.
  - Keeps the array inferable as block RAM.
- The FSM, wait counter, decode and tri-state driver live in bus_memory_responder.

Test Plan:
- Reset: assert reset 2 cycles with req=1 -> ack=0, err=0, busy=0, data=Z; no transaction accepted while reset high.
- Write then read (WAIT_STATES=2, BASE=0): write 0xDEADBEEF to address 5, ack exactly 3 cycles after accept; then read address 5 -> data=0xDEADBEEF only in the ack cycle, err=0, Z before and after.
- Out of range (DEPTH=1024): read address 1024 -> ack with err=1, data=0. Write 0x1234 to address 0xFFFFFFFF -> err=1, and a subsequent read of address 1023 is unchanged.
- Back-to-back (WAIT_STATES=0): hold req=1 with three reads at addresses 0, 1, 2 preloaded 0xA, 0xB, 0xC -> ack every other cycle, data 0xA, 0xB, 0xC in order.
- Reset mid-wait: write 0x55 to address 7 with WAIT_STATES=3, assert reset in second WAIT cycle -> no ack; later read of address 7 returns prior value.
- BASE offset (BASE=0x100): write 0x77 to address 0x100, read address 0x100 -> 0x77, err=0. Read address 0xFF -> err=1.
